// File: rtl/life_generation_ctrl.sv
// Game of Life generation controller: owns the board register and
// commits the datapath's next generation on single steps or at a set rate.
module life_generation_ctrl #(
  parameter int CELLS = 256,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CELLS-1:0] seed,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] period,
  input  logic [CELLS-1:0] grid_evolve,
  output logic [CELLS-1:0] grid,
  output logic [15:0]      gen_count,
  output logic             gen_tick,
  output logic             running,
  output logic             stable,
  output logic             extinct
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t           r_state, w_state_n;
  logic [DIV_W-1:0] r_div, w_div_n;
  logic [CELLS-1:0] r_grid, w_grid_n;
  logic [15:0]      r_gen, w_gen_n;
  logic             r_tick, w_tick_n;
  logic             r_stable, w_stable_n;
  logic             r_extinct, w_extinct_n;

  logic [DIV_W-1:0] w_per;
  logic             w_due;
  logic             w_same;
  logic             w_eval;

  // A period of 0 behaves as 1: one generation per cycle
  assign w_per  = (period == '0) ? DIV_W'(1) : period;
  assign w_due  = (r_div >= (w_per - DIV_W'(1)));
  assign w_same = (grid_evolve == r_grid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_grid    <= '0;
      r_gen     <= '0;
      r_tick    <= 1'b0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_div     <= w_div_n;
      r_grid    <= w_grid_n;
      r_gen     <= w_gen_n;
      r_tick    <= w_tick_n;
      r_stable  <= w_stable_n;
      r_extinct <= w_extinct_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_div_n     = r_div;
    w_grid_n    = r_grid;
    w_gen_n     = r_gen;
    w_tick_n    = 1'b0;
    w_stable_n  = r_stable;
    w_extinct_n = r_extinct;
    w_eval      = 1'b0;
    if (load) begin
      w_grid_n    = seed;
      w_gen_n     = '0;
      w_div_n     = '0;
      w_stable_n  = 1'b0;
      w_extinct_n = (seed == '0);
      w_state_n   = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!stop && start) begin
            w_state_n = S_RUN;
            w_div_n   = '0;
          end else if (!stop && step) begin
            w_eval = 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            w_state_n = S_IDLE;
            w_div_n   = '0;
          end else if (w_due) begin
            w_eval  = 1'b1;
            w_div_n = '0;
          end else begin
            w_div_n = r_div + DIV_W'(1);
          end
        end
        S_HALTED: begin
          if (stop) begin
            w_state_n  = S_IDLE;
            w_stable_n = 1'b0;
          end
        end
        default: ;
      endcase
      // An unchanged board is a still life: no commit, RUN halts
      if (w_eval) begin
        if (w_same) begin
          w_stable_n = 1'b1;
          if (r_state == S_RUN) w_state_n = S_HALTED;
        end else begin
          w_grid_n    = grid_evolve;
          w_gen_n     = r_gen + 16'd1;
          w_tick_n    = 1'b1;
          w_extinct_n = (grid_evolve == '0);
        end
      end
    end
  end

  assign grid      = r_grid;
  assign gen_count = r_gen;
  assign gen_tick  = r_tick;
  assign running   = (r_state == S_RUN);
  assign stable    = r_stable;
  assign extinct   = r_extinct;

endmodule
